// File: rtl/unidade_controle_jogo_pkg.sv
// jogo_pkg: shared definitions for the Memory Challenge control unit.
//   - estado_t: 4-bit state codes; these are the values exposed on db_estado.
//   - MODO_BIT_TIMEOUT: bit of the mode register that enables the inactivity timeout.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    INICIO_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROXIMO       = 4'h6,
    PROX_RODADA   = 4'h7,
    FIM_ACERTO    = 4'hA,
    FIM_ERRO      = 4'hE,
    FIM_TIMEOUT   = 4'hF
  } estado_t;

  localparam int MODO_BIT_TIMEOUT = 0;

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// contador_timeout: inactivity timer for the game control unit.
// Ports:
//   clock  in  : system clock, rising edge
//   zera   in  : synchronous clear (wins over conta)
//   conta  in  : count enable, +1 per cycle
//   fim    out : count has reached T_LIMITE-1
// The count saturates at T_LIMITE-1 so a long wait with timeout disabled
// never wraps back and fakes a fresh start.
module contador_timeout #(
  parameter int T_LIMITE = 3000,
  parameter int W_T      = 12
) (
  input  logic clock,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [W_T-1:0] ULTIMO = W_T'(T_LIMITE - 1);

  logic [W_T-1:0] cont_q;
  logic [W_T-1:0] cont_d;

  always_comb begin
    cont_d = cont_q;
    if (zera) begin
      cont_d = '0;
    end else if (conta && (cont_q != ULTIMO)) begin
      cont_d = cont_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    cont_q <= cont_d;
  end

  assign fim = (cont_q == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing the Memory Challenge datapath.
// Ports:
//   clock, reset (sync, active-high)
//   iniciar        : start/restart request (level)
//   jogada         : one-cycle pulse per button press
//   igual          : stored play equals memory word
//   fim_endereco   : address counter at current round limit
//   fim_limite     : round limit at last position
//   modo[1:0]      : mode register; bit0 enables timeout
//   zera_/conta_endereco, zera_/conta_limite, zera_jogada, registra_jogada,
//   registra_modo  : datapath strobes, one cycle per state visit
//   pronto, acertou, errou, timeout : end-of-game flags, held until iniciar
//   db_estado[3:0] : current state code
// Input protocol: jogada is a single-cycle pulse; igual must be valid in
// COMPARA, one cycle after registra_jogada loads the play register.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int T_LIMITE = 3000,
  parameter int W_T      = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_endereco,
  input  logic       fim_limite,
  input  logic [1:0] modo,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_limite,
  output logic       conta_limite,
  output logic       zera_jogada,
  output logic       registra_jogada,
  output logic       registra_modo,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado_q;
  estado_t estado_d;
  logic    fim_tempo;
  logic    unused_modo_alto;

  // modo[1] belongs to the datapath only.
  assign unused_modo_alto = modo[1];

  // Timer runs only while waiting for a play; every other state (and reset)
  // clears it so each ESPERA visit starts from zero.
  contador_timeout #(
    .T_LIMITE(T_LIMITE),
    .W_T     (W_T)
  ) u_timer (
    .clock(clock),
    .zera (reset || (estado_q != ESPERA)),
    .conta(estado_q == ESPERA),
    .fim  (fim_tempo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state decoder.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:    estado_d = INICIO_RODADA;
      INICIO_RODADA: estado_d = ESPERA;
      ESPERA: begin
        // A play in the expiry cycle still counts.
        if (jogada) begin
          estado_d = REGISTRA;
        end else if (modo[MODO_BIT_TIMEOUT] && fim_tempo) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      REGISTRA:      estado_d = COMPARA;
      COMPARA: begin
        if (!igual) begin
          estado_d = FIM_ERRO;
        end else if (!fim_endereco) begin
          estado_d = PROXIMO;
        end else if (fim_limite) begin
          estado_d = FIM_ACERTO;
        end else begin
          estado_d = PROX_RODADA;
        end
      end
      PROXIMO:       estado_d = ESPERA;
      PROX_RODADA:   estado_d = INICIO_RODADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default:       estado_d = INICIAL;
    endcase
  end

  // Output decoder: depends on estado_q only.
  always_comb begin
    zera_endereco   = 1'b0;
    conta_endereco  = 1'b0;
    zera_limite     = 1'b0;
    conta_limite    = 1'b0;
    zera_jogada     = 1'b0;
    registra_jogada = 1'b0;
    registra_modo   = 1'b0;
    pronto          = 1'b0;
    acertou         = 1'b0;
    errou           = 1'b0;
    timeout         = 1'b0;
    case (estado_q)
      PREPARACAO: begin
        zera_endereco = 1'b1;
        zera_limite   = 1'b1;
        zera_jogada   = 1'b1;
        registra_modo = 1'b1;
      end
      INICIO_RODADA: zera_endereco   = 1'b1;
      REGISTRA:      registra_jogada = 1'b1;
      PROXIMO:       conta_endereco  = 1'b1;
      PROX_RODADA:   conta_limite    = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;

  localparam int T_LIM = 10;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0;
  logic       fim_endereco = 1'b0, fim_limite = 1'b0;
  logic [1:0] modo = 2'b00;
  logic zera_endereco, conta_endereco, zera_limite, conta_limite;
  logic zera_jogada, registra_jogada, registra_modo;
  logic pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int n_cmp  = 0;
  int n_fail = 0;

  unidade_controle_jogo #(.T_LIMITE(T_LIM), .W_T(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .jogada         (jogada),
    .igual          (igual),
    .fim_endereco   (fim_endereco),
    .fim_limite     (fim_limite),
    .modo           (modo),
    .zera_endereco  (zera_endereco),
    .conta_endereco (conta_endereco),
    .zera_limite    (zera_limite),
    .conta_limite   (conta_limite),
    .zera_jogada    (zera_jogada),
    .registra_jogada(registra_jogada),
    .registra_modo  (registra_modo),
    .pronto         (pronto),
    .acertou        (acertou),
    .errou          (errou),
    .timeout        (timeout),
    .db_estado      (db_estado)
  );

  // Bit order: zera_end, conta_end, zera_lim, conta_lim, zera_jog,
  // reg_jog, reg_modo, pronto, acertou, errou, timeout.
  logic [10:0] saidas;
  assign saidas = {zera_endereco, conta_endereco, zera_limite, conta_limite,
                   zera_jogada, registra_jogada, registra_modo,
                   pronto, acertou, errou, timeout};

  // Expected strobes/flags for each state code, hand-written from the state table.
  function automatic logic [10:0] esperado(input logic [3:0] e);
    case (e)
      4'h1:    return 11'b10101010000;
      4'h2:    return 11'b10000000000;
      4'h4:    return 11'b00000100000;
      4'h6:    return 11'b01000000000;
      4'h7:    return 11'b00010000000;
      4'hA:    return 11'b00000001100;
      4'hE:    return 11'b00000001010;
      4'hF:    return 11'b00000001001;
      default: return 11'b00000000000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] s);
    {iniciar, jogada, igual, fim_endereco, fim_limite} = s;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    iniciar = 1'b1;   // reset must win over iniciar
    tick();
    tick();
    if (db_estado !== 4'h0 || saidas !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: estado=%h saidas=%b, expected estado=0 saidas=0", db_estado, saidas);
    end
    n_cmp++;
    reset = 1'b0;
    iniciar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (db_estado !== 4'h0 || saidas !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: estado=%h saidas=%b, expected estado=0 saidas=0", i, db_estado, saidas);
      end
      n_cmp++;
    end
  endtask

  task automatic test_full_game();
    logic [8:0] tab [16] = '{
      {5'b10000, 4'h1}, {5'b00000, 4'h2}, {5'b00000, 4'h3}, {5'b01000, 4'h4},
      {5'b00110, 4'h5}, {5'b00110, 4'h7}, {5'b00000, 4'h2}, {5'b00000, 4'h3},
      {5'b01000, 4'h4}, {5'b00100, 4'h5}, {5'b00100, 4'h6}, {5'b00000, 4'h3},
      {5'b01000, 4'h4}, {5'b00111, 4'h5}, {5'b00111, 4'hA}, {5'b00000, 4'hA}
    };
    int n_prox_rodada = 0;
    modo = 2'b00;
    foreach (tab[i]) begin
      drive(tab[i][8:4]);
      tick();
      if (db_estado == 4'h7) n_prox_rodada++;
      if (db_estado !== tab[i][3:0] || saidas !== esperado(tab[i][3:0])) begin
        n_fail++;
        $display("FAIL full_game step %0d: estado=%h saidas=%b, expected estado=%h saidas=%b",
                 i, db_estado, saidas, tab[i][3:0], esperado(tab[i][3:0]));
      end
      n_cmp++;
    end
    if (n_prox_rodada !== 1) begin
      n_fail++;
      $display("FAIL full_game_prox_rodada: visits=%0d, expected 1", n_prox_rodada);
    end
    n_cmp++;
  endtask

  task automatic test_wrong_play();
    // igual=0 with fim_endereco/fim_limite=1 checks the COMPARA priority.
    logic [8:0] tab [10] = '{
      {5'b10000, 4'h1}, {5'b00000, 4'h2}, {5'b00000, 4'h3}, {5'b01000, 4'h4},
      {5'b00100, 4'h5}, {5'b00100, 4'h6}, {5'b00000, 4'h3}, {5'b01000, 4'h4},
      {5'b00011, 4'h5}, {5'b00011, 4'hE}
    };
    foreach (tab[i]) begin
      drive(tab[i][8:4]);
      tick();
      if (db_estado !== tab[i][3:0] || saidas !== esperado(tab[i][3:0])) begin
        n_fail++;
        $display("FAIL wrong_play step %0d: estado=%h saidas=%b, expected estado=%h saidas=%b",
                 i, db_estado, saidas, tab[i][3:0], esperado(tab[i][3:0]));
      end
      n_cmp++;
    end
    drive(5'b00000);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (db_estado !== 4'hE || saidas !== 11'b00000001010) begin
        n_fail++;
        $display("FAIL wrong_play_hold cycle %0d: estado=%h saidas=%b, expected estado=e saidas=00000001010",
                 i, db_estado, saidas);
      end
      n_cmp++;
    end
  endtask

  task automatic test_restart();
    logic [3:0] exp_e [4] = '{4'h1, 4'h2, 4'h3, 4'h3};
    int n_zl = 0, n_zj = 0, n_rm = 0;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? 5'b10000 : 5'b00000);
      tick();
      n_zl += int'(zera_limite);
      n_zj += int'(zera_jogada);
      n_rm += int'(registra_modo);
      if (db_estado !== exp_e[i] || saidas !== esperado(exp_e[i])) begin
        n_fail++;
        $display("FAIL restart step %0d: estado=%h saidas=%b, expected estado=%h saidas=%b",
                 i, db_estado, saidas, exp_e[i], esperado(exp_e[i]));
      end
      n_cmp++;
    end
    if (n_zl !== 1 || n_zj !== 1 || n_rm !== 1) begin
      n_fail++;
      $display("FAIL restart_pulses: zera_limite=%0d zera_jogada=%0d registra_modo=%0d cycles, expected 1 each",
               n_zl, n_zj, n_rm);
    end
    n_cmp++;
  endtask

  // Entered ESPERA during the previous test; one edge has already elapsed there.
  task automatic test_timeout();
    logic [3:0] exp_e;
    // Restart so ESPERA is entered at a known edge k.
    modo = 2'b01;
    drive(5'b00000);
    tick();  // leave nothing pending: still ESPERA, now re-run cleanly
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(5'b10000); tick();
    drive(5'b00000); tick();
    tick();  // edge k: ESPERA entered
    for (int j = 1; j <= T_LIM + 2; j++) begin
      tick();
      exp_e = (j >= T_LIM) ? 4'hF : 4'h3;
      if (db_estado !== exp_e || saidas !== esperado(exp_e)) begin
        n_fail++;
        $display("FAIL timeout edge k+%0d: estado=%h saidas=%b, expected estado=%h saidas=%b",
                 j, db_estado, saidas, exp_e, esperado(exp_e));
      end
      n_cmp++;
    end
    // Timeout disabled: stays waiting.
    modo = 2'b00;
    drive(5'b10000); tick();
    drive(5'b00000); tick();
    tick();
    for (int j = 0; j < 50; j++) begin
      tick();
      if (db_estado !== 4'h3) begin
        n_fail++;
        $display("FAIL no_timeout cycle %0d: estado=%h, expected estado=3", j, db_estado);
      end
      n_cmp++;
    end
  endtask

  // Starts in ESPERA with the timer saturated and timeout disabled.
  task automatic test_race();
    logic [3:0] exp_e;
    // Enable timeout and play in the same cycle: the play must win.
    modo = 2'b01;
    drive(5'b01000);
    tick();
    if (db_estado !== 4'h4) begin
      n_fail++;
      $display("FAIL race_saturated: estado=%h, expected estado=4", db_estado);
    end
    n_cmp++;
    for (int r = 0; r < 2; r++) begin
      drive(5'b00100); tick();   // COMPARA
      tick();                    // PROXIMO
      drive(5'b00000); tick();   // edge k: ESPERA entered
      if (db_estado !== 4'h3) begin
        n_fail++;
        $display("FAIL race_entry round %0d: estado=%h, expected estado=3", r, db_estado);
      end
      n_cmp++;
      for (int j = 1; j < T_LIM; j++) begin
        tick();
        if (db_estado !== 4'h3) begin
          n_fail++;
          $display("FAIL race_wait round %0d edge k+%0d: estado=%h, expected estado=3", r, j, db_estado);
        end
        n_cmp++;
      end
      // Expiry cycle: round 0 plays now, round 1 lets it expire.
      drive(r == 0 ? 5'b01000 : 5'b00000);
      tick();
      exp_e = (r == 0) ? 4'h4 : 4'hF;
      if (db_estado !== exp_e || saidas !== esperado(exp_e)) begin
        n_fail++;
        $display("FAIL race_expiry round %0d: estado=%h saidas=%b, expected estado=%h saidas=%b",
                 r, db_estado, saidas, exp_e, esperado(exp_e));
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_game();
    modo = 2'b00;
    drive(5'b10000); tick();
    drive(5'b00000); tick();
    tick();
    tick();
    if (db_estado !== 4'h3) begin
      n_fail++;
      $display("FAIL mid_game_setup: estado=%h, expected estado=3", db_estado);
    end
    n_cmp++;
    reset = 1'b1;
    drive(5'b11000);
    tick();
    if (db_estado !== 4'h0 || saidas !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_game_reset: estado=%h saidas=%b, expected estado=0 saidas=0", db_estado, saidas);
    end
    n_cmp++;
    reset = 1'b0;
    drive(5'b10000);
    tick();
    if (db_estado !== 4'h1 || registra_modo !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_game_restart: estado=%h registra_modo=%b, expected estado=1 registra_modo=1",
               db_estado, registra_modo);
    end
    n_cmp++;
    drive(5'b00000);
    tick();
    if (db_estado !== 4'h2 || saidas !== 11'b10000000000) begin
      n_fail++;
      $display("FAIL mid_game_next: estado=%h saidas=%b, expected estado=2 saidas=10000000000", db_estado, saidas);
    end
    n_cmp++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full_game();
    test_wrong_play();
    test_restart();
    test_timeout();
    test_race();
    test_reset_mid_game();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
